// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Data-memory access stage placed after the ALU of a single-cycle core.
// It takes the effective address, the store data and the RISC-V funct3 of a
// load/store. It runs one req/gnt/rvalid transaction to a variable-latency
// data memory. For loads it returns sign- or zero-extended data. While an
// access is in flight it stalls the core.
//
// Parameters
//   ADDR_WIDTH      byte address width, core side and memory side
//   TIMEOUT_CYCLES  maximum REQ+WAIT cycles before a forced error completion
//                   (0 disables the timeout)
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       core presents a load/store (held until stall drops)
//   req_we          1 = store, 0 = load
//   req_funct3      RISC-V funct3 (access size and signedness)
//   req_addr        effective byte address
//   req_wdata       right-aligned store data
//   stall           core must hold PC, instruction and request
//   rdata           extended load data, qualified by resp_valid
//   resp_valid      one-cycle completion pulse
//   err             error completion (bad funct3, timeout, misaligned)
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata  memory request side
//   mem_gnt         memory accepted the request
//   mem_rvalid      read data valid (never in the same cycle as its gnt)
//   mem_rdata       read word
//
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses
//                         complete with err = 1 and make no memory access.
//                         When undefined, the low address bits that do not
//                         matter for the access size are ignored.
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,

    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  resp_valid,
    output logic                  err,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    // The counter can step one past TIMEOUT_CYCLES when a load is granted on
    // the last allowed cycle, so leave headroom above the limit.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 3);

    state_t             r_state;
    state_t             w_state_next;

    logic               r_mem_we;
    logic [2:0]         r_funct3;
    logic [1:0]         r_lane;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [3:0]         r_mem_wstrb;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_legal;
    logic               w_misaligned;
    logic               w_access_ok;
    logic               w_timeout;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_wdata;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_data;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~req_we;  // LBU/LHU have no store form
            default:                w_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_access_ok = w_legal && !w_misaligned;

    // Store lane strobes and lane-replicated data. Loads present no strobes.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << req_addr[1:0];
                    w_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    w_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = req_wdata;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Load data selection and extension (funct3[2] = 1 means unsigned)
    // -------------------------------------------------------------------------
    always_comb begin
        w_byte      = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half      = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_data = mem_rdata;
        case (r_funct3[1:0])
            2'b00:   w_load_data = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
            2'b01:   w_load_data = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // A grant or rvalid arriving on the limit cycle wins over the timeout,
    // because the FSM checks those first.
    assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                       ((r_cnt + CNT_W'(1)) >= CNT_W'(TIMEOUT_CYCLES));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        resp_valid   = 1'b0;
        // Combinational so that a request stalls the core from its first cycle.
        stall        = req_valid && (r_state != S_RESP);

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_next = w_access_ok ? S_REQ : S_RESP;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    w_state_next = r_mem_we ? S_RESP : S_WAIT;  // stores are posted
                end else if (w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_WAIT: begin
                if (mem_rvalid || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we    <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_wstrb <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_rdata <= 32'h0;
                        r_err   <= !w_access_ok;
                        // A rejected request leaves the memory side untouched.
                        if (w_access_ok) begin
                            r_mem_we    <= req_we;
                            r_funct3    <= req_funct3;
                            r_lane      <= req_addr[1:0];
                            r_mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            r_mem_wstrb <= w_wstrb;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (!mem_gnt && w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_rdata <= w_load_data;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_state_next == S_IDLE) begin
                r_cnt <= '0;
            end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;
    assign err       = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. Each transaction's timeline
// (stall/mem_req/resp_valid per cycle), memory-side fields and completion
// data are predicted from cycle arithmetic and plain integer math. The bench
// acts as the data memory: it raises gnt/rvalid on the cycles it has chosen.
// The expected results come from those chosen cycles, not from the DUT.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int AW = 32;
    localparam int TO = 64;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          stall;
    logic [31:0]   rdata;
    logic          resp_valid;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rdata      (rdata),
        .resp_valid (resp_valid),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- reference model helpers --------------------------------
    function automatic bit legal_f3(input bit we, input logic [2:0] f3);
        int v;
        v = int'(f3);
        if (we) return (v <= 2);
        return (v <= 2) || (v == 4) || (v == 5);
    endfunction

    function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
        bit m;
        m = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (f3[1:0] == 2'b01) m = (a % 2) != 0;
        if (f3[1:0] == 2'b10) m = (a % 4) != 0;
`endif
        return m;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        int          byte_ofs;
        byte_ofs = int'(a % 4);
        if (f3[1:0] == 2'b00) begin
            v = (w >> (8 * byte_ofs)) % 256;
            if (!f3[2] && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'b01) begin
            v = (w >> (16 * (byte_ofs / 2))) % 65536;
            if (!f3[2] && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input bit we, input logic [2:0] f3,
                                            input logic [31:0] a);
        int byte_ofs;
        byte_ofs = int'(a % 4);
        if (!we) return 4'd0;
        if (f3[1:0] == 2'b00) return 4'(1 << byte_ofs);
        if (f3[1:0] == 2'b01) return (byte_ofs >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (f3[1:0] == 2'b00) return (w % 256) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    // ---------------- one transaction ----------------------------------------
    // gnt_dly: REQ cycles without gnt before the grant; rv_dly: WAIT cycles
    // without rvalid before read data. Cycle 0 is the first request cycle.
    task automatic run_txn(input string name, input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rword, input int gnt_dly, input int rv_dly);
        bit access, tmo, e_err;
        int k_g, k_r, k_end, req_end, resp_c, lim;
        logic [31:0] e_rdata;

        access  = legal_f3(we, f3) && !misaligned(f3, a);
        tmo     = 1'b0;
        k_g     = gnt_dly + 1;
        k_r     = k_g + rv_dly + 1;
        k_end   = 0;
        req_end = 0;
        if (access) begin
            if (k_g > TO) begin
                tmo   = 1'b1;
                k_end = TO;
            end else if (we) begin
                k_end = k_g;
            end else begin
                // after a grant on the last allowed cycle, the next cycle is
                // the earliest the timeout can fire
                lim = (k_g + 1 > TO) ? k_g + 1 : TO;
                if (k_r <= lim) k_end = k_r;
                else begin
                    tmo   = 1'b1;
                    k_end = lim;
                end
            end
            req_end = (k_g < TO) ? k_g : TO;
            resp_c  = k_end + 1;
        end else begin
            resp_c  = 1;
        end
        e_err   = !access || tmo;
        e_rdata = e_err ? 32'h0 : exp_load(f3, a, rword);

        for (int c = 0; c <= resp_c; c++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_we     = we;
            req_funct3 = f3;
            req_addr   = a;
            req_wdata  = wd;
            mem_gnt    = access && (c == k_g) && (k_g <= k_end);
            mem_rvalid = access && !we && !tmo && (c == k_r);
            mem_rdata  = mem_rvalid ? rword : $urandom;
            #1;
            check({name, ":ctl"}, 32'({stall, mem_req, resp_valid}),
                  32'({c < resp_c, access && (c >= 1) && (c <= req_end), c == resp_c}));
            if (access && c == 1) begin
                check({name, ":addr"}, mem_addr, {a[31:2], 2'b00});
                check({name, ":we"}, 32'(mem_we), 32'(we));
                check({name, ":strb"}, 32'(mem_wstrb), 32'(exp_strb(we, f3, a)));
                if (we) check({name, ":wdata"}, mem_wdata, exp_wdata(f3, wd));
            end
            if (c == resp_c) begin
                check({name, ":err"}, 32'(err), 32'(e_err));
                if (!we || e_err) check({name, ":rdata"}, rdata, e_rdata);
            end
        end
        @(negedge clk);
        req_valid  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check({name, ":idle"}, 32'({stall, mem_req, resp_valid}), 32'd0);
    endtask

    // ---------------- stimulus ------------------------------------------------
    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst:ctl", 32'({stall, resp_valid, err, mem_req, mem_we, mem_wstrb}), 32'd0);
        check("rst:rdata", rdata, 32'h0);
        check("rst:maddr", mem_addr, 32'h0);
        check("rst:mwdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        run_txn("lw",      1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1);
        run_txn("lb",      1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
        run_txn("lbu",     1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 2);
        run_txn("lh",      1'b0, 3'b001, 32'h202, 32'h0, 32'h9ABC_1234, 2, 0);
        run_txn("lhu",     1'b0, 3'b101, 32'h200, 32'h0, 32'h1234_F00D, 0, 0);
        run_txn("sh",      1'b1, 3'b001, 32'h22,  32'h1234_ABCD, 32'h0, 0, 0);
        run_txn("sb",      1'b1, 3'b000, 32'h41,  32'hCAFE_F05A, 32'h0, 3, 0);
        run_txn("sw",      1'b1, 3'b010, 32'h44,  32'h0BAD_F00D, 32'h0, 1, 0);
        run_txn("bad_ld",  1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
        run_txn("bad_st",  1'b1, 3'b100, 32'h100, 32'h1, 32'h0, 0, 0);
        run_txn("lw_mis",  1'b0, 3'b010, 32'h102, 32'h0, 32'h1357_9BDF, 0, 0);
        run_txn("tmo_req", 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1000, 0);
        run_txn("st_edge", 1'b1, 3'b010, 32'h304, 32'h55AA_55AA, 32'h0, TO - 1, 0);
        run_txn("ld_edge", 1'b0, 3'b010, 32'h308, 32'h0, 32'h7777_0001, 10, TO - 13);
        run_txn("tmo_wt",  1'b0, 3'b001, 32'h30A, 32'h0, 32'h0, 5, 200);
        run_txn("ld_lgnt", 1'b0, 3'b000, 32'h30D, 32'h0, 32'h00A5_0000, TO - 1, 0);

        // reset during WAIT, then a stray rvalid must be ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr  = 32'h100; mem_gnt = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("rstw:wait", 32'({stall, mem_req, resp_valid}), 32'b100);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rstw:ctl", 32'({stall, resp_valid, err, mem_req, mem_we, mem_wstrb}), 32'd0);
        check("rstw:rdata", rdata, 32'h0);
        check("rstw:maddr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rstw:ign", 32'({stall, mem_req, resp_valid, err}), 32'd0);
        end
        mem_rvalid = 1'b0;

        // randomized transactions
        for (int t = 0; t < 60; t++) begin
            bit          we;
            logic [2:0]  f3;
            int          gd, rd;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            gd = ($urandom_range(0, 15) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 3));
            rd = ($urandom_range(0, 15) == 0) ? int'($urandom_range(50, 70)) : int'($urandom_range(0, 3));
            run_txn("rnd", we, f3, $urandom, $urandom, $urandom, gd, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the single-cycle core's ALU.
- Takes the ALU-computed effective address plus rs2 store data and load/store type from the core, and runs a req/gnt/rvalid handshake to a variable-latency data memory.
- Returns sign/zero-extended load data for write-back.
- Drives a stall that freezes the PC and register write enable until the access completes.

Parameters:
- ADDR_WIDTH, 32, byte address width on both core and memory sides.
- TIMEOUT_CYCLES, 64, maximum cycles spent in REQ+WAIT before forced error completion; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core presents a load/store this cycle; held until the stall drops.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: size and signedness.
- req_addr  in  ADDR_WIDTH  effective byte address (ALU result).
- req_wdata  in  32  store data (RD2), right-aligned.
- stall  out  1  core must hold PC, instruction and request.
- rdata  out  32  extended load data; valid only while resp_valid = 1.
- resp_valid  out  1  one-cycle completion pulse.
- err  out  1  completion with error (bad funct3, timeout, misaligned); qualified by resp_valid.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] = 0.
- mem_wstrb  out  4  byte-lane write strobes.
- mem_wdata  out  32  lane-replicated write data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  read data valid; never asserted in the same cycle as the accepting gnt.
- mem_rdata  in  32  read word.

Behaviour:
- Reset: state = IDLE. stall, resp_valid, err, mem_req, mem_we, mem_wstrb = 0. rdata, mem_addr, mem_wdata = 0. Timeout counter = 0. Assertion of rst_n low mid-transaction aborts immediately; any later gnt/rvalid is ignored.
- States and transitions:
  - IDLE:
    - req_valid with legal funct3 → REQ; the memory outputs are latched from the request.
    - req_valid with illegal funct3 → RESP with err = 1.
  - REQ: mem_req = 1.
    - mem_gnt with a store → RESP.
    - mem_gnt with a load → WAIT.
  - WAIT: mem_rvalid → RESP; rdata is captured and extended.
  - RESP: resp_valid = 1 for exactly one cycle → IDLE. A new request is sampled no earlier than the following cycle.
- stall = req_valid && state != RESP. This is combinational, so a request stalls from its first cycle. The core completes the instruction in the RESP cycle.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Everything else is illegal and produces no memory access.
- Stores:
  - SB: strobe = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: strobe = 0011 or 1100 by addr[1]; wdata = {2{wdata[15:0]}}.
  - SW: strobe = 1111.
- Loads:
  - The byte or halfword is selected by addr[1:0] or addr[1], then sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - A load reports mem_wstrb = 0000.
- Timeout:
  - The counter increments every cycle in REQ or WAIT and clears on entering IDLE.
  - When it reaches TIMEOUT_CYCLES, the state goes to RESP with err = 1 and rdata = 0, and mem_req drops.
  - If gnt/rvalid arrives on that same cycle, normal completion takes priority.
- Store completion on gnt is posted; no rvalid is expected for stores.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, goes IDLE → RESP with err = 1 and rdata = 0. No memory access is made.
- Undefined: misalignment is not checked. The low address bits are ignored for word accesses, and for halfword accesses addr[0] is ignored. The access proceeds normally with err = 0.

Test Plan:
- LW addr 0x100, gnt after 1 cycle, rvalid 2 cycles later with 0xDEADBEEF → stall for 4 cycles, then one resp_valid with rdata 0xDEADBEEF, err 0.
- LB addr 0x103, mem_rdata 0x80FF_0000 → rdata 0xFFFFFF80. Same word with LBU → rdata 0x00000080.
- SH addr 0x22, wdata 0x1234ABCD, gnt immediate → mem_addr 0x20, wstrb 1100, mem_wdata 0xABCDABCD; resp 2 cycles after req_valid.
- Load with gnt never asserted, TIMEOUT_CYCLES = 64 → resp_valid with err = 1 and rdata = 0 after 64 cycles in REQ; mem_req deasserted afterwards.
- funct3 = 011 load → no mem_req, resp_valid + err in the cycle after req_valid.
- rst_n low during WAIT, then rvalid asserted → all outputs 0 immediately; no resp_valid. With LSU_MISALIGN_TRAP_EN defined, LW at 0x102 → err = 1 and no mem_req.
